// File: rtl/pe_cell_apb_pkg.sv
// Shared types and constants for the PE-cell APB requester and its boot sequencer.
// The boot table is only consumed when PE_CELL_APB_MST_BOOT_EN is defined.
package pe_cell_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [3:0] SET_CYCLE0 = 4'h0;
    localparam logic [3:0] SET_CYCLE1 = 4'h1;
    localparam logic [3:0] SET_CYCLE2 = 4'h2;
    localparam logic [3:0] SET_CYCLE3 = 4'h3;
    localparam logic [3:0] REUSE      = 4'h4;

    localparam int BOOT_LEN   = 5;
    localparam int BOOT_IDX_W = $clog2(BOOT_LEN + 1);

    // Element 0 sits in the low byte, so entry i is written to address i.
    localparam logic [BOOT_LEN-1:0][7:0] BOOT_DATA = {8'h61, 8'h00, 8'h00, 8'h00, 8'h10};
    localparam logic [BOOT_LEN-1:0][3:0] BOOT_ADDR = {REUSE, SET_CYCLE3, SET_CYCLE2,
                                                      SET_CYCLE1, SET_CYCLE0};

    function automatic logic [7:0] boot_data_at(input logic [BOOT_IDX_W-1:0] idx);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < BOOT_LEN; i++)
            if (idx == BOOT_IDX_W'(i)) d = BOOT_DATA[i];
        return d;
    endfunction

    function automatic logic [3:0] boot_addr_at(input logic [BOOT_IDX_W-1:0] idx);
        logic [3:0] a;
        a = '0;
        for (int i = 0; i < BOOT_LEN; i++)
            if (idx == BOOT_IDX_W'(i)) a = BOOT_ADDR[i];
        return a;
    endfunction

endpackage

// File: rtl/pe_cell_apb_master_boot.sv
// Boot sequencer: walks the package boot table, one entry per boot_next pulse.
// Only instantiated when PE_CELL_APB_MST_BOOT_EN is defined.
module pe_cell_apb_boot_seq
    import pe_cell_apb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_next,
    output logic              boot_valid,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [DATA_W-1:0] boot_data,
    output logic              boot_done
);

    logic [BOOT_IDX_W-1:0] idx;

    // Advances on completion or abort alike, so a timed-out entry is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (boot_next && boot_valid)
            idx <= idx + 1'b1;
    end

    assign boot_done  = (idx == BOOT_IDX_W'(BOOT_LEN));
    assign boot_valid = !boot_done;
    assign boot_addr  = ADDR_W'(boot_addr_at(idx));
    assign boot_data  = DATA_W'(boot_data_at(idx));

endmodule

// File: rtl/pe_cell_apb_master.sv
// APB requester for the PE-cell register slave: valid/ready command in, one-cycle response out.
// Define PE_CELL_APB_MST_BOOT_EN to issue the boot-table writes after reset.
module pe_cell_apb_master
    import pe_cell_apb_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int DLY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              boot_done,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_t        state;
    logic              is_boot;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_inc;
    logic              abort;
    logic              xfer_end;
    logic              boot_valid;
    logic              boot_next;
    logic              boot_done_i;
    logic [ADDR_W-1:0] boot_addr;
    logic [DATA_W-1:0] boot_data;

`ifdef PE_CELL_APB_MST_BOOT_EN
    pe_cell_apb_boot_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_boot (
        .clk        (clk),
        .rst_n      (rst_n),
        .boot_next  (boot_next),
        .boot_valid (boot_valid),
        .boot_addr  (boot_addr),
        .boot_data  (boot_data),
        .boot_done  (boot_done_i)
    );
`else
    assign boot_valid  = 1'b0;
    assign boot_addr   = '0;
    assign boot_data   = '0;
    assign boot_done_i = 1'b1;
    logic unused_boot_next;
    assign unused_boot_next = boot_next;
`endif

    // DLY is accepted for interface compatibility; this RTL carries no delays.
    logic unused_dly;
    assign unused_dly = (DLY != 0);

    assign boot_done = boot_done_i;
    assign cmd_ready = (state == ST_IDLE) && boot_done_i;

    // Abort on the TIMEOUT-th consecutive pready=0 ACCESS cycle.
    assign wait_inc  = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
    assign abort     = (TIMEOUT != 0) && !pready && (wait_inc == CNT_W'(TIMEOUT));
    assign xfer_end  = (state == ST_ACCESS) && (pready || abort);
    assign boot_next = xfer_end && is_boot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_boot   <= 1'b0;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (boot_valid) begin
                        paddr    <= boot_addr;
                        pwdata   <= boot_data;
                        pwrite   <= 1'b1;
                        is_boot  <= 1'b1;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end else if (cmd_valid && cmd_ready) begin
                        paddr    <= cmd_addr;
                        pwdata   <= cmd_wdata;
                        pwrite   <= cmd_write;
                        is_boot  <= 1'b0;
                        wait_cnt <= '0;
                        psel     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (xfer_end) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                        if (!is_boot) begin
                            rsp_valid <= 1'b1;
                            rsp_write <= pwrite;
                            rsp_err   <= !pready;
                            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cell_apb_master.sv
// Self-checking bench for pe_cell_apb_master: vector table plus reset and boot sequences.
module tb_pe_cell_apb_master;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_write, rsp_err;
    logic [7:0] rsp_rdata;
    logic       busy, boot_done;
    logic       psel, penable, pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pready;

    pe_cell_apb_master #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TO), .DLY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .boot_done(boot_done),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] sdata;
        int         waits;
        logic       stuck;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    vec_t vecs[8];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   rsp_cnt = 0;
    int   exp_rsp = 0;

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic boot_check();
        logic [7:0] bexp[5];
        int nb = 0;
        int n = 0;
        bexp = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h61};
`ifdef PE_CELL_APB_MST_BOOT_EN
        pready = 1'b1;
        prdata = 8'h00;
        while (boot_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (psel && penable) begin
                check("boot_addr", paddr, nb);
                check("boot_pwrite", pwrite, 1);
                if (nb < 5) check("boot_data", pwdata, bexp[nb]);
                nb++;
            end
        end
        pready = 1'b0;
        check("boot_count", nb, 5);
`else
        check("boot_table_unused", nb, 0);
        check("boot_first", bexp[0], 8'h10);
`endif
        check("boot_done", boot_done, 1);
        check("boot_cmd_ready", cmd_ready, 1);
        check("boot_no_rsp", rsp_cnt, exp_rsp);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int   n_acc;
        exp_t e;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        exp_q.push_back('{v.wr, v.exp_rdata, v.exp_err});
        exp_rsp++;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = 8'h00;
        check({nm, "_setup_psel"}, {psel, penable}, 2'b10);
        check({nm, "_setup_ready"}, cmd_ready, 0);
        check({nm, "_paddr"}, paddr, v.addr);
        check({nm, "_pwrite"}, pwrite, v.wr);
        if (v.wr) check({nm, "_pwdata"}, pwdata, v.wdata);
        n_acc = v.stuck ? TO : v.waits + 1;
        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            check({nm, "_access"}, {psel, penable, cmd_ready, busy}, 4'b1101);
            pready = !v.stuck && (k == v.waits);
            prdata = (k == v.waits) ? v.sdata : 8'hEE;
        end
        @(negedge clk);
        pready = 1'b0;
        prdata = 8'h00;
        check({nm, "_rsp_valid"}, rsp_valid, 1);
        check({nm, "_idle"}, {psel, penable, busy, cmd_ready}, 4'b0001);
        check({nm, "_paddr_hold"}, paddr, v.addr);
        if (exp_q.size() == 0) begin
            check({nm, "_exp_q"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_rsp_write"}, rsp_write, e.wr);
            check({nm, "_rsp_rdata"}, rsp_rdata, e.rdata);
            check({nm, "_rsp_err"}, rsp_err, e.err);
        end
        @(negedge clk);
        check({nm, "_rsp_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'h0, 8'h5A, 8'h00, 0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 4'h4, 8'h00, 8'h61, 0, 1'b0, 8'h61, 1'b0};
        vecs[2] = '{1'b0, 4'h1, 8'h00, 8'h3C, 3, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 4'h3, 8'hFF, 8'h77, 2, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 4'h2, 8'h00, 8'h99, 0, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 4'h4, 8'h00, 8'hA5, 0, 1'b0, 8'hA5, 1'b0};
        vecs[6] = '{1'b1, 4'hF, 8'h00, 8'h12, 1, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 4'h0, 8'h00, 8'h81, TO - 1, 1'b0, 8'h81, 1'b0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_rdata, busy}, '0);
`ifdef PE_CELL_APB_MST_BOOT_EN
        check("rst_ready_boot", {cmd_ready, boot_done}, 2'b00);
`else
        check("rst_ready_boot", {cmd_ready, boot_done}, 2'b11);
`endif
        rst_n = 1'b1;
        boot_check();

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted mid-ACCESS: bus drops at once and the command vanishes.
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstmid_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_async", {psel, penable, busy, rsp_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rstmid_no_rsp", rsp_cnt, exp_rsp);
        boot_check();
        run_vec("post_rst", vecs[1]);

        check("rsp_total", rsp_cnt, exp_rsp);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
